// File: rtl/iic_uart_pkg.sv
// Shared types and constants for the I2C-to-UART transmit buffer.
// Holds the pacing FSM states, the ASCII constants and the nibble-to-ASCII
// helper used when the IIC_UART_HEX_EN build option is enabled.
package iic_uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } tx_state_t;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_A     = 8'h41;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   // Character slot that the next IDLE visit loads in hex mode.
   localparam logic [1:0] CHAR_HI = 2'd0;
   localparam logic [1:0] CHAR_LO = 2'd1;
   localparam logic [1:0] CHAR_SP = 2'd2;

   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      logic [7:0] result;
      if (nib < 4'd10) begin
         result = ASCII_ZERO + {4'd0, nib};
      end else begin
         result = ASCII_A + {4'd0, nib} - 8'd10;
      end
      return result;
   endfunction

endpackage

// File: rtl/iic_uart_fifo.sv
// Synchronous byte FIFO for the I2C-to-UART buffer.
// Pure storage: the caller decides when a push or pop is legal, this block
// only moves pointers, tracks the fill level and reports full/empty.
module iic_uart_fifo #(
   parameter int FIFO_DEPTH = 16,
   localparam int FIFO_AW   = $clog2(FIFO_DEPTH)
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               push,
   input  logic [7:0]         push_data,
   input  logic               pop,
   output logic [7:0]         head_data,
   output logic [FIFO_AW:0]   level,
   output logic               full,
   output logic               empty
);

   localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW+1)'(FIFO_DEPTH);

   logic [7:0]         mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;

   // Pointers wrap naturally because the depth is a power of two; a
   // simultaneous push and pop leaves the level unchanged.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + FIFO_AW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + (FIFO_AW+1)'(1);
            2'b01:   level <= level - (FIFO_AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage array carries no reset so it maps onto plain RAM.
   always_ff @(posedge sys_clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign head_data = mem[rd_ptr];
   assign full      = (level == FULL_LEVEL);
   assign empty     = (level == '0);

endmodule

// File: rtl/iic_uart_tx_buf.sv
// I2C-to-UART transmit buffer: queues bytes from the I2C slave receiver and
// releases them to the UART transmitter one frame at a time, waiting for
// tx_done between frames. Sticky flags report dropped bytes and a stalled
// transmitter.
// Build option IIC_UART_HEX_EN: each byte goes out as two ASCII hex digits
// followed by a space, three frames per FIFO pop.
module iic_uart_tx_buf
   import iic_uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int TX_TIMEOUT = 65536,
   parameter int TO_W       = 17,
   localparam int FIFO_AW   = $clog2(FIFO_DEPTH)
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic [7:0]         in_data,
   input  logic               in_vld,
   output logic [7:0]         tx_data,
   output logic               tx_flag,
   input  logic               tx_done,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow,
   output logic               timeout_err,
   input  logic               clr_err
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TX_TIMEOUT - 1);

   tx_state_t       state;
   tx_state_t       state_next;

   logic            pop;
   logic            push_ok;
   logic            drop;
   logic [7:0]      fifo_head;
   logic            fifo_full;
   logic            fifo_empty;

   logic            load_en;
   logic [7:0]      load_val;
   logic            cnt_clr;
   logic            cnt_inc;
   logic            to_hit;
   logic [TO_W-1:0] to_cnt;

`ifdef IIC_UART_HEX_EN
   logic [1:0]      char_idx;
   logic [1:0]      char_idx_next;
   logic [7:0]      hex_byte;
`endif

   // A full FIFO can still accept a byte when the FSM frees a slot this cycle.
   assign push_ok = in_vld && (!fifo_full || pop);
   assign drop    = in_vld && !push_ok;

   iic_uart_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .push       (push_ok),
      .push_data  (in_data),
      .pop        (pop),
      .head_data  (fifo_head),
      .level      (fifo_level),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   // Pacing FSM state register.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and datapath controls; returning through IDLE after every
   // frame guarantees at least two cycles between tx_done and the next tx_flag.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      load_en    = 1'b0;
      load_val   = tx_data;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      to_hit     = 1'b0;
`ifdef IIC_UART_HEX_EN
      char_idx_next = char_idx;
`endif
      case (state)
         IDLE: begin
`ifdef IIC_UART_HEX_EN
            if (char_idx == CHAR_LO) begin
               load_en       = 1'b1;
               load_val      = nibble_to_ascii(hex_byte[3:0]);
               char_idx_next = CHAR_SP;
               state_next    = SEND;
            end else if (char_idx == CHAR_SP) begin
               load_en       = 1'b1;
               load_val      = ASCII_SPACE;
               char_idx_next = CHAR_HI;
               state_next    = SEND;
            end else if (!fifo_empty) begin
               pop           = 1'b1;
               load_en       = 1'b1;
               load_val      = nibble_to_ascii(fifo_head[7:4]);
               char_idx_next = CHAR_LO;
               state_next    = SEND;
            end
`else
            if (!fifo_empty) begin
               pop        = 1'b1;
               load_en    = 1'b1;
               load_val   = fifo_head;
               state_next = SEND;
            end
`endif
         end
         SEND: begin
            cnt_clr    = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            if (tx_done) begin
               state_next = IDLE;
            end else if (to_cnt == TO_LAST) begin
               to_hit     = 1'b1;
               state_next = IDLE;
`ifdef IIC_UART_HEX_EN
               char_idx_next = CHAR_HI;
`endif
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign tx_flag = (state == SEND);

   // Outgoing character register and the tx_done watchdog counter.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         tx_data <= '0;
         to_cnt  <= '0;
      end else begin
         if (load_en) begin
            tx_data <= load_val;
         end
         if (cnt_clr) begin
            to_cnt <= '0;
         end else if (cnt_inc) begin
            to_cnt <= to_cnt + TO_W'(1);
         end
      end
   end

   // Sticky error flags; a set event in the same cycle as clr_err wins.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         overflow    <= (overflow && !clr_err) || drop;
         timeout_err <= (timeout_err && !clr_err) || to_hit;
      end
   end

`ifdef IIC_UART_HEX_EN
   // Character slot tracker and a copy of the popped byte for the low nibble.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         char_idx <= CHAR_HI;
         hex_byte <= '0;
      end else begin
         char_idx <= char_idx_next;
         if (pop) begin
            hex_byte <= fifo_head;
         end
      end
   end
`endif

endmodule

// File: tb/tb_iic_uart_tx_buf.sv
// Self-checking bench for iic_uart_tx_buf: a scoreboard queue holds the
// characters expected on the UART side and is popped on every tx_flag.
// Define IIC_UART_HEX_EN for both files to exercise the hex build.
`timescale 1ns/1ps
module tb_iic_uart_tx_buf;

   localparam int FIFO_DEPTH = 16;
   localparam int TX_TIMEOUT = 1000;
   localparam int TO_W       = 17;
   localparam int FIFO_AW    = 4;

   logic               sys_clk = 1'b0;
   logic               sys_rst = 1'b0;
   logic [7:0]         in_data = '0;
   logic               in_vld  = 1'b0;
   logic               tx_done = 1'b0;
   logic               clr_err = 1'b0;
   logic [7:0]         tx_data;
   logic               tx_flag;
   logic [FIFO_AW:0]   fifo_level;
   logic               overflow;
   logic               timeout_err;

   int         compareCount = 0;
   int         mismatchCount = 0;
   int         cyc = 0;
   int         flagCount = 0;
   int         lastFlagCyc = -1;
   bit         inFlight = 1'b0;
   logic [7:0] expQ[$];

   iic_uart_tx_buf #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .TX_TIMEOUT (TX_TIMEOUT),
      .TO_W       (TO_W)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .in_data     (in_data),
      .in_vld      (in_vld),
      .tx_data     (tx_data),
      .tx_flag     (tx_flag),
      .tx_done     (tx_done),
      .fifo_level  (fifo_level),
      .overflow    (overflow),
      .timeout_err (timeout_err),
      .clr_err     (clr_err)
   );

   // 50 MHz system clock.
   always #10 sys_clk = ~sys_clk;

   // Cycle counter used for latency measurements.
   always @(posedge sys_clk) cyc = cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // UART-side monitor: every start strobe consumes one scoreboard entry.
   always @(negedge sys_clk) begin
      if (sys_rst && tx_flag) begin
         flagCount++;
         lastFlagCyc = cyc;
         checkOutput("flag_before_done", 32'(inFlight), 32'd0);
         inFlight = 1'b1;
         if (expQ.size() == 0) begin
            checkOutput("sb_empty_at_flag", 32'(expQ.size()), 32'd1);
         end else begin
            checkOutput("tx_data", 32'(tx_data), 32'(expQ.pop_front()));
         end
      end
   end

   task automatic nextCycle();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input bit pushExp);
      in_data = b;
      in_vld  = 1'b1;
      if (pushExp) expQ.push_back(b);
      nextCycle();
      in_vld  = 1'b0;
   endtask

   task automatic pulseDone();
      tx_done = 1'b1;
      nextCycle();
      tx_done  = 1'b0;
      inFlight = 1'b0;
   endtask

   task automatic waitFlag(input int budget, output bit seen);
      seen = inFlight;
      for (int i = 0; i < budget && !seen; i++) begin
         nextCycle();
         seen = inFlight;
      end
   endtask

   task automatic waitUntil(input int target);
      while (cyc < target) nextCycle();
   endtask

   task automatic drainAll(input int budget);
      int spent = 0;
      while ((expQ.size() != 0 || inFlight) && spent < budget) begin
         if (inFlight) begin
            repeat (3) nextCycle();
            pulseDone();
            spent += 4;
         end else begin
            nextCycle();
            spent++;
         end
      end
      checkOutput("drain_left", 32'(expQ.size()), 32'd0);
   endtask

   // Hard stop in case the stimulus itself hangs.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int  c0;
      int  f0;
      int  startFlags;
      bit  seen;

      $display("[TB] start");
      repeat (3) nextCycle();
      checkOutput("rst_tx_flag", 32'(tx_flag), 32'd0);
      checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
      checkOutput("rst_level", 32'(fifo_level), 32'd0);
      checkOutput("rst_overflow", 32'(overflow), 32'd0);
      checkOutput("rst_timeout", 32'(timeout_err), 32'd0);
      sys_rst = 1'b1;
      repeat (2) nextCycle();

`ifdef IIC_UART_HEX_EN
      $display("[TB] hex encoding");
      startFlags = flagCount;
      expQ.push_back(8'h33);
      expQ.push_back(8'h43);
      expQ.push_back(8'h20);
      applyStimulus(8'h3C, 1'b0);
      waitFlag(10, seen);
      checkOutput("hex_first_flag", 32'(seen), 32'd1);
      expQ.push_back(8'h46);
      expQ.push_back(8'h30);
      expQ.push_back(8'h20);
      applyStimulus(8'hF0, 1'b0);
      checkOutput("hex_level_a", 32'(fifo_level), 32'd1);
      repeat (5) nextCycle();
      checkOutput("hex_wait_done", 32'(flagCount - startFlags), 32'd1);
      pulseDone();
      waitFlag(10, seen);
      checkOutput("hex_second_flag", 32'(seen), 32'd1);
      checkOutput("hex_level_b", 32'(fifo_level), 32'd1);
      pulseDone();
      waitFlag(10, seen);
      checkOutput("hex_third_flag", 32'(seen), 32'd1);
      checkOutput("hex_level_c", 32'(fifo_level), 32'd1);
      drainAll(500);
      checkOutput("hex_frames", 32'(flagCount - startFlags), 32'd6);
      checkOutput("hex_level_end", 32'(fifo_level), 32'd0);
`else
      $display("[TB] single byte");
      startFlags = flagCount;
      c0 = cyc;
      applyStimulus(8'hA5, 1'b1);
      waitFlag(10, seen);
      checkOutput("single_flag_seen", 32'(seen), 32'd1);
      checkOutput("single_latency", 32'(lastFlagCyc), 32'(c0 + 2));
      waitUntil(c0 + 100);
      pulseDone();
      repeat (20) nextCycle();
      checkOutput("single_flag_count", 32'(flagCount - startFlags), 32'd1);
      checkOutput("single_data_held", 32'(tx_data), 32'hA5);
      checkOutput("single_level", 32'(fifo_level), 32'd0);

      $display("[TB] burst and clear race");
      startFlags = flagCount;
      for (int i = 0; i < 20; i++) applyStimulus(8'(i), i <= 16);
      checkOutput("burst_level", 32'(fifo_level), 32'd16);
      checkOutput("burst_overflow", 32'(overflow), 32'd1);
      in_data = 8'h77;
      in_vld  = 1'b1;
      clr_err = 1'b1;
      nextCycle();
      in_vld  = 1'b0;
      clr_err = 1'b0;
      checkOutput("race_overflow_kept", 32'(overflow), 32'd1);
      clr_err = 1'b1;
      nextCycle();
      clr_err = 1'b0;
      checkOutput("race_overflow_clear", 32'(overflow), 32'd0);
      checkOutput("race_level_kept", 32'(fifo_level), 32'd16);
      drainAll(2000);
      checkOutput("burst_sent", 32'(flagCount - startFlags), 32'd17);
      checkOutput("burst_level_end", 32'(fifo_level), 32'd0);
      checkOutput("burst_no_overflow", 32'(overflow), 32'd0);

      $display("[TB] timeout");
      applyStimulus(8'h11, 1'b1);
      applyStimulus(8'h22, 1'b1);
      waitFlag(10, seen);
      checkOutput("to_first_flag", 32'(seen), 32'd1);
      f0 = lastFlagCyc;
      waitUntil(f0 + 1000);
      checkOutput("to_err_early", 32'(timeout_err), 32'd0);
      waitUntil(f0 + 1001);
      checkOutput("to_err_set", 32'(timeout_err), 32'd1);
      inFlight = 1'b0;
      waitFlag(10, seen);
      checkOutput("to_second_flag", 32'(seen), 32'd1);
      checkOutput("to_second_latency", 32'(lastFlagCyc), 32'(f0 + 1002));

      $display("[TB] reset mid-wait");
      for (int i = 0; i < 5; i++) applyStimulus(8'hC0 + 8'(i), 1'b0);
      checkOutput("prerst_level", 32'(fifo_level), 32'd5);
      sys_rst = 1'b0;
      #1;
      expQ.delete();
      inFlight = 1'b0;
      checkOutput("midrst_tx_flag", 32'(tx_flag), 32'd0);
      checkOutput("midrst_tx_data", 32'(tx_data), 32'd0);
      checkOutput("midrst_level", 32'(fifo_level), 32'd0);
      checkOutput("midrst_overflow", 32'(overflow), 32'd0);
      checkOutput("midrst_timeout", 32'(timeout_err), 32'd0);
      repeat (2) nextCycle();
      sys_rst = 1'b1;
      startFlags = flagCount;
      repeat (50) nextCycle();
      checkOutput("postrst_no_flag", 32'(flagCount - startFlags), 32'd0);
      applyStimulus(8'h5A, 1'b1);
      drainAll(200);
      checkOutput("postrst_one_flag", 32'(flagCount - startFlags), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
